// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg: shared states, host command codes and default widths for the MIPS debug controller
package mips_debug_pkg;
  localparam int NB_BYTE_DEF = 8;
  localparam int NB_DUMP_DEF = 304;
  localparam int NB_INST_DEF = 32;
  typedef enum logic [2:0] {IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, DUMP, ACK} state_t;
  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] CMD_RESET = 8'h58;
  localparam logic [7:0] ACK_CODE  = 8'h4B;
endpackage

// File: rtl/mips_dump_serializer.sv
// mips_dump_serializer: captures a vector on start and streams its top n_bytes bytes MSB first over a valid/ready link
module mips_dump_serializer #(
  parameter int NB_BYTE = 8,
  parameter int NB_VEC  = 304
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              start,
  input  logic [NB_VEC-1:0] vec,
  input  logic [5:0]        n_bytes,
  input  logic              tx_ready,
  output logic [NB_BYTE-1:0] tx_data,
  output logic              tx_valid,
  output logic              done
);
  logic [NB_VEC-1:0] snap;
  logic [5:0] left;
  assign tx_data = snap[NB_VEC-1 -: NB_BYTE];
  // snapshot on start, then shift one byte out per accepted handshake; done pulses after the last one
  always_ff @(posedge clk) begin
    if (i_reset) begin
      snap <= '0;
      left <= '0;
      tx_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        snap <= vec;
        left <= n_bytes;
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        snap <= snap << NB_BYTE;
        left <= left - 6'd1;
        tx_valid <= left != 6'd1;
        done <= left == 6'd1;
      end
    end
  end
endmodule

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: host-link sequencer that loads, runs, steps and dumps the pipelined MIPS core
module mips_debug_ctrl
  import mips_debug_pkg::*;
#(
  parameter int NB_BYTE = NB_BYTE_DEF,
  parameter int NB_DUMP = NB_DUMP_DEF,
  parameter int NB_INST = NB_INST_DEF
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_we_IF,
  output logic [NB_INST-1:0] o_instruction_data,
  output logic [NB_INST-1:0] o_instruction_addr,
  output logic               o_step,
  output logic               o_mips_reset,
  input  logic               i_end,
  input  logic [NB_DUMP-1:0] i_dump,
  output logic               o_busy
);
  localparam logic [5:0] DUMP_BYTES = 6'(NB_DUMP / NB_BYTE);
  state_t state;
  logic [7:0] k, n;
  logic [1:0] nbyte;
  logic [NB_INST-NB_BYTE-1:0] word;
  logic ser_start, ser_done;
  logic [NB_DUMP-1:0] ser_vec;
  logic [5:0] ser_len;
  assign o_busy = state != IDLE;
  assign ser_vec = state == ACK ? {ACK_CODE, {(NB_DUMP-NB_BYTE){1'b0}}} : i_dump;
  assign ser_len = state == ACK ? 6'd1 : DUMP_BYTES;
  mips_dump_serializer #(.NB_BYTE(NB_BYTE), .NB_VEC(NB_DUMP)) u_ser (
    .clk(clk),
    .i_reset(i_reset),
    .start(ser_start),
    .vec(ser_vec),
    .n_bytes(ser_len),
    .tx_ready(i_tx_ready),
    .tx_data(o_tx_data),
    .tx_valid(o_tx_valid),
    .done(ser_done)
  );
  // command sequencer: decode in IDLE, assemble and write instructions, gate the core clock-enable, launch responses
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= IDLE;
      k <= '0;
      n <= '0;
      nbyte <= '0;
      word <= '0;
      o_we_IF <= 1'b0;
      o_instruction_data <= '0;
      o_instruction_addr <= '0;
      o_step <= 1'b1;
      o_mips_reset <= 1'b0;
      ser_start <= 1'b0;
    end else begin
      o_we_IF <= 1'b0;
      o_mips_reset <= 1'b0;
      ser_start <= 1'b0;
      case (state)
        IDLE: if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state <= LOAD_CNT;
            CMD_RUN: begin
              state <= RUN;
              o_step <= i_end;
            end
            CMD_STEP: begin
              state <= STEP;
              o_step <= i_end;
            end
            CMD_DUMP: begin
              state <= DUMP;
              ser_start <= 1'b1;
            end
            CMD_RESET: begin
              state <= ACK;
              ser_start <= 1'b1;
              o_mips_reset <= 1'b1;
            end
            default: ;
          endcase
        end
        LOAD_CNT: if (i_rx_valid) begin
          n <= i_rx_data;
          k <= '0;
          nbyte <= '0;
          state <= i_rx_data == '0 ? ACK : LOAD_BYTE;
          ser_start <= i_rx_data == '0;
        end
        LOAD_BYTE: if (i_rx_valid) begin
          word <= {word[NB_INST-2*NB_BYTE-1:0], i_rx_data};
          nbyte <= nbyte + 2'd1;
          if (nbyte == 2'd3) begin
            state <= LOAD_WR;
            o_we_IF <= 1'b1;
            o_instruction_data <= {word, i_rx_data};
            o_instruction_addr <= NB_INST'({k, 2'b00});
          end
        end
        LOAD_WR: begin
          k <= k + 8'd1;
          state <= k + 8'd1 == n ? ACK : LOAD_BYTE;
          ser_start <= k + 8'd1 == n;
        end
        RUN: begin
          o_step <= i_end;
          if (i_end) begin
            state <= DUMP;
            ser_start <= 1'b1;
          end
        end
        STEP: begin
          o_step <= 1'b1;
          state <= DUMP;
          ser_start <= 1'b1;
        end
        DUMP, ACK: if (ser_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
